// File: rtl/rv_multicycle_ctrl_if.sv
// Control and handshake bundle between the RV32I multi-cycle controller and its datapath/memory.
// The master side (controller) drives the controls and reads the IR, the memory ack and the branch result.
interface rv_multicycle_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int XLEN  = 32
);
  logic [XLEN-1:0]  instr;
  logic             mem_ack;
  logic             br_taken;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic [2:0]       ext_op;
  logic [1:0]       alu_a_sel;
  logic             alu_b_sel;
  logic [3:0]       alu_ctrl;
  logic             rf_we;
  logic [1:0]       wd_sel;
  logic             illegal;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instr, mem_ack, br_taken,
    output ir_we, pc_we, pc_sel, mem_req, mem_we, addr_sel, ext_op,
           alu_a_sel, alu_b_sel, alu_ctrl, rf_we, wd_sel, illegal, state_o, instret
  );

  modport slave (
    output instr, mem_ack, br_taken,
    input  ir_we, pc_we, pc_sel, mem_req, mem_we, addr_sel, ext_op,
           alu_a_sel, alu_b_sel, alu_ctrl, rf_we, wd_sel, illegal, state_o, instret
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle main controller for the RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencing over a
// shared memory port, with instruction decode into EXT/ALU/RF/PC controls and a retired-instruction counter.
module rv_multicycle_ctrl #(
  parameter int CNT_W = 32,
  parameter int XLEN  = 32
) (
  input logic                 clk,
  input logic                 rstn,
  rv_multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  state_e           state_q;
  logic [CNT_W-1:0] instret_q;

  logic [XLEN-1:0]  ir_w;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             unused_ir;

  logic isLoad, isStore, isOpImm, isOp, isLui, isAuipc, isBranch, isJal, isJalr;
  logic supported;
  logic isMemOp, isFlowOp;

  logic [2:0] extDec;
  logic [1:0] aSelDec;
  logic       bSelDec;
  logic [3:0] aluCtrlDec;

  logic       ir_we_w, pc_we_w, mem_req_w, mem_we_w, addr_sel_w, alu_b_sel_w, rf_we_w, illegal_w;
  logic [1:0] pc_sel_w, alu_a_sel_w, wd_sel_w;
  logic [2:0] ext_op_w;
  logic [3:0] alu_ctrl_w;

  assign ir_w     = bus.instr;
  assign opcode   = ir_w[6:0];
  assign funct3   = ir_w[14:12];
  assign funct7b5 = ir_w[30];
  assign unused_ir = ^{ir_w[31], ir_w[29:15], ir_w[11:7]};

  always_comb begin
    isLoad   = (opcode == OPC_LOAD);
    isStore  = (opcode == OPC_STORE);
    isOpImm  = (opcode == OPC_OPIMM);
    isOp     = (opcode == OPC_OP);
    isLui    = (opcode == OPC_LUI);
    isAuipc  = (opcode == OPC_AUIPC);
    isBranch = (opcode == OPC_BRANCH);
    isJal    = (opcode == OPC_JAL);
    isJalr   = (opcode == OPC_JALR);
  end

  assign supported = isLoad | isStore | isOpImm | isOp | isLui | isAuipc | isBranch | isJal | isJalr;
  assign isMemOp   = isLoad | isStore;
  assign isFlowOp  = isBranch | isJal | isJalr;

  // Immediate format for the EXT block; shift-immediates need the 5-bit shamt form.
  always_comb begin
    extDec = 3'b000;
    if (isOpImm)               extDec = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b110 : 3'b010;
    else if (isLoad || isJalr) extDec = 3'b010;
    else if (isStore)          extDec = 3'b001;
    else if (isBranch)         extDec = 3'b011;
    else if (isLui || isAuipc) extDec = 3'b100;
    else if (isJal)            extDec = 3'b101;
  end

  // funct7[5] only selects sub/sra for register ops; for immediates it matters only on right shifts.
  always_comb begin
    aSelDec    = 2'b00;
    bSelDec    = 1'b0;
    aluCtrlDec = 4'b0000;
    if (isOp) begin
      aluCtrlDec = {funct7b5, funct3};
    end else if (isOpImm) begin
      bSelDec    = 1'b1;
      aluCtrlDec = {funct7b5 & (funct3 == 3'b101), funct3};
    end else if (isLoad || isStore || isJalr) begin
      bSelDec = 1'b1;
    end else if (isLui) begin
      aSelDec = 2'b10;
      bSelDec = 1'b1;
    end else if (isAuipc) begin
      aSelDec = 2'b01;
      bSelDec = 1'b1;
    end
  end

  always_comb begin
    ir_we_w     = 1'b0;
    pc_we_w     = 1'b0;
    pc_sel_w    = 2'b00;
    mem_req_w   = 1'b0;
    mem_we_w    = 1'b0;
    addr_sel_w  = 1'b0;
    ext_op_w    = 3'b000;
    alu_a_sel_w = 2'b00;
    alu_b_sel_w = 1'b0;
    alu_ctrl_w  = 4'b0000;
    rf_we_w     = 1'b0;
    wd_sel_w    = 2'b00;
    illegal_w   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req_w = 1'b1;
        if (bus.mem_ack) begin
          ir_we_w = 1'b1;
          pc_we_w = 1'b1;
        end
      end
      DECODE: begin
        ext_op_w = extDec;
      end
      EXEC: begin
        ext_op_w    = extDec;
        alu_a_sel_w = aSelDec;
        alu_b_sel_w = bSelDec;
        alu_ctrl_w  = aluCtrlDec;
        if (isBranch) begin
          pc_we_w  = bus.br_taken;
          pc_sel_w = 2'b01;
        end else if (isJal || isJalr) begin
          rf_we_w  = 1'b1;
          wd_sel_w = 2'b10;
          pc_we_w  = 1'b1;
          pc_sel_w = isJalr ? 2'b10 : 2'b01;
        end
      end
      MEM: begin
        ext_op_w    = extDec;
        alu_a_sel_w = aSelDec;
        alu_b_sel_w = bSelDec;
        alu_ctrl_w  = aluCtrlDec;
        mem_req_w   = 1'b1;
        addr_sel_w  = 1'b1;
        mem_we_w    = isStore;
      end
      WB: begin
        ext_op_w    = extDec;
        alu_a_sel_w = aSelDec;
        alu_b_sel_w = bSelDec;
        alu_ctrl_w  = aluCtrlDec;
        rf_we_w     = 1'b1;
        wd_sel_w    = isLoad ? 2'b01 : 2'b00;
      end
      TRAP: begin
        illegal_w = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // instret advances on the edge that leaves an instruction's final state; TRAP never retires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      instret_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (bus.mem_ack) state_q <= DECODE;
        end
        DECODE: state_q <= supported ? EXEC : TRAP;
        EXEC: begin
          if (isMemOp) begin
            state_q <= MEM;
          end else if (isFlowOp) begin
            state_q   <= FETCH;
            instret_q <= instret_q + 1'b1;
          end else begin
            state_q <= WB;
          end
        end
        MEM: begin
          if (bus.mem_ack) begin
            if (isStore) begin
              state_q   <= FETCH;
              instret_q <= instret_q + 1'b1;
            end else begin
              state_q <= WB;
            end
          end
        end
        WB: begin
          state_q   <= FETCH;
          instret_q <= instret_q + 1'b1;
        end
        TRAP: state_q <= TRAP;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ir_we     = ir_we_w;
  assign bus.pc_we     = pc_we_w;
  assign bus.pc_sel    = pc_sel_w;
  assign bus.mem_req   = mem_req_w;
  assign bus.mem_we    = mem_we_w;
  assign bus.addr_sel  = addr_sel_w;
  assign bus.ext_op    = ext_op_w;
  assign bus.alu_a_sel = alu_a_sel_w;
  assign bus.alu_b_sel = alu_b_sel_w;
  assign bus.alu_ctrl  = alu_ctrl_w;
  assign bus.rf_we     = rf_we_w;
  assign bus.wd_sel    = wd_sel_w;
  assign bus.illegal   = illegal_w;
  assign bus.state_o   = state_q;
  assign bus.instret   = instret_q;

endmodule
